// File: rtl/arc_shape_renderer_if.sv
// Draw-request and pixel-output bundle for arc_shape_renderer.
// With ARC_SHAPE_STATS_EN defined the plot/clip counters travel on it too.
interface arc_shape_renderer_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic                mode;
  logic [COLOUR_W-1:0] colour;
  logic [X_W-1:0]      centre_x;
  logic [Y_W-1:0]      centre_y;
  logic [X_W-1:0]      diameter;
  logic                done;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
`ifdef ARC_SHAPE_STATS_EN
  logic [15:0]         plot_count;
  logic [15:0]         clip_count;

  modport master (
    output start, mode, colour, centre_x, centre_y, diameter,
    input  done, vga_x, vga_y, vga_colour, vga_plot, plot_count, clip_count
  );
  modport slave (
    input  start, mode, colour, centre_x, centre_y, diameter,
    output done, vga_x, vga_y, vga_colour, vga_plot, plot_count, clip_count
  );
`else
  modport master (
    output start, mode, colour, centre_x, centre_y, diameter,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );
  modport slave (
    input  start, mode, colour, centre_x, centre_y, diameter,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
`endif
endinterface

// File: rtl/arc_shape_renderer.sv
// Midpoint circle / Reuleaux triangle rasteriser, one candidate pixel per clock.
// Optional ARC_SHAPE_STATS_EN adds saturating plot/clip counters.

// Squared-distance test of one candidate pixel against one vertex.
module arc_dist_chk #(
  parameter int CW = 11,
  parameter int PW = 26
) (
  input  logic signed [CW-1:0] px,
  input  logic signed [CW-1:0] py,
  input  logic signed [CW-1:0] vx,
  input  logic signed [CW-1:0] vy,
  input  logic signed [PW-1:0] dsq,
  output logic                 ok
);
  logic signed [CW:0]   dx, dy;
  logic signed [PW-1:0] dxw, dyw;

  always_comb begin
    dx  = {px[CW-1], px} - {vx[CW-1], vx};
    dy  = {py[CW-1], py} - {vy[CW-1], vy};
    dxw = PW'(dx);
    dyw = PW'(dy);
    ok  = (dxw * dxw + dyw * dyw) <= dsq;
  end
endmodule

module arc_shape_renderer #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic                 clk,
  input logic                 rst_n,
  arc_shape_renderer_if.slave bus
);
  // Wide enough for a vertex offset plus a full-diameter radius in either axis.
  localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 3;
  localparam int KW = CW + 2;
  localparam int PW = 2 * CW + 4;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] DRAW     = 3'd2;
  localparam logic [2:0] NEXT_ARC = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic signed [CW-1:0] SCR_W = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SCR_H = CW'(SCREEN_H);
  localparam logic signed [KW-1:0] ONE_K = KW'(1);

  logic [2:0]          state;
  logic                mode_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [X_W-1:0]      cx_q;
  logic [Y_W-1:0]      cy_q;
  logic [X_W-1:0]      d_q;
  logic [1:0]          arc;
  logic [2:0]          oct;
  logic signed [CW-1:0] ox, oy, r_q, ccx, ccy;
  logic signed [KW-1:0] crit;
  logic signed [CW-1:0] vx [3];
  logic signed [CW-1:0] vy [3];
  logic signed [PW-1:0] dsq;

  // Shape geometry derived from the latched request
  logic signed [CW-1:0] cx_s, cy_s, half, h1, h2;
  logic [X_W+6:0]       m37, m74;

  always_comb begin
    cx_s = CW'(cx_q);
    cy_s = CW'(cy_q);
    half = CW'(d_q >> 1);
    m37  = (X_W+7)'(d_q) * (X_W+7)'(37);
    m74  = (X_W+7)'(d_q) * (X_W+7)'(74);
    h1   = CW'(m37 >> 7);
    h2   = CW'(m74 >> 7);
  end

  // Candidate pixel for the current octant
  logic signed [CW-1:0] px, py;

  always_comb begin
    px = ccx;
    py = ccy;
    case (oct)
      3'd0: begin px = ccx + ox; py = ccy + oy; end
      3'd1: begin px = ccx + oy; py = ccy + ox; end
      3'd2: begin px = ccx - ox; py = ccy + oy; end
      3'd3: begin px = ccx - oy; py = ccy + ox; end
      3'd4: begin px = ccx - ox; py = ccy - oy; end
      3'd5: begin px = ccx - oy; py = ccy - ox; end
      3'd6: begin px = ccx + ox; py = ccy - oy; end
      default: begin px = ccx + oy; py = ccy - ox; end
    endcase
  end

  logic [2:0] near;
  logic       accept, on_scr;

  for (genvar i = 0; i < 3; i++) begin : g_vtx
    arc_dist_chk #(.CW(CW), .PW(PW)) u_chk (
      .px(px), .py(py), .vx(vx[i]), .vy(vy[i]), .dsq(dsq), .ok(near[i])
    );
  end

  // Reuleaux arcs keep only points inside the disc of both other vertices.
  always_comb begin
    accept = 1'b1;
    if (mode_q)
      for (int i = 0; i < 3; i++)
        if (int'(arc) != i && !near[i]) accept = 1'b0;
    on_scr = !px[CW-1] && !py[CW-1] && (px < SCR_W) && (py < SCR_H);
  end

  // Midpoint step applied after the eighth octant
  logic signed [CW-1:0] oy_n, ox_n;
  logic signed [KW-1:0] oyk, oxk, crit_n;
  logic                 arc_end;

  always_comb begin
    oy_n = oy + CW'(1);
    if (crit[KW-1] || crit == '0) begin
      ox_n   = ox;
      oyk    = KW'(oy_n);
      oxk    = KW'(ox_n);
      crit_n = crit + oyk + oyk + ONE_K;
    end else begin
      ox_n   = ox - CW'(1);
      oyk    = KW'(oy_n);
      oxk    = KW'(ox_n);
      crit_n = crit + (oyk - oxk) + (oyk - oxk) + ONE_K;
    end
    arc_end = oy_n > ox_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mode_q         <= 1'b0;
      colour_q       <= '0;
      cx_q           <= '0;
      cy_q           <= '0;
      d_q            <= '0;
      arc            <= '0;
      oct            <= '0;
      ox             <= '0;
      oy             <= '0;
      r_q            <= '0;
      ccx            <= '0;
      ccy            <= '0;
      crit           <= '0;
      dsq            <= '0;
      for (int i = 0; i < 3; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
      bus.done       <= 1'b0;
      bus.vga_plot   <= 1'b0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
    end else begin
      bus.vga_plot <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q   <= bus.mode;
            colour_q <= bus.colour;
            cx_q     <= bus.centre_x;
            cy_q     <= bus.centre_y;
            d_q      <= bus.diameter;
            state    <= SETUP;
          end
        end
        SETUP: begin
          vx[0] <= cx_s - half;
          vy[0] <= cy_s + h1;
          vx[1] <= cx_s + half;
          vy[1] <= cy_s + h1;
          vx[2] <= cx_s;
          vy[2] <= cy_s - h2;
          dsq   <= PW'(d_q) * PW'(d_q);
          arc   <= '0;
          oct   <= '0;
          oy    <= '0;
          if (mode_q) begin
            ccx  <= cx_s - half;
            ccy  <= cy_s + h1;
            r_q  <= CW'(d_q);
            ox   <= CW'(d_q);
            crit <= ONE_K - KW'(d_q);
          end else begin
            ccx  <= cx_s;
            ccy  <= cy_s;
            r_q  <= half;
            ox   <= half;
            crit <= ONE_K - KW'(half);
          end
          state <= (d_q == '0) ? DONE : DRAW;
        end
        DRAW: begin
          if (accept && on_scr) begin
            bus.vga_plot   <= 1'b1;
            bus.vga_x      <= px[X_W-1:0];
            bus.vga_y      <= py[Y_W-1:0];
            bus.vga_colour <= colour_q;
          end
          oct <= oct + 3'd1;
          if (oct == 3'd7) begin
            oy   <= oy_n;
            ox   <= ox_n;
            crit <= crit_n;
            if (arc_end) begin
              if (!mode_q || arc == 2'd2) begin
                state <= DONE;
              end else begin
                arc   <= arc + 2'd1;
                state <= NEXT_ARC;
              end
            end
          end
        end
        NEXT_ARC: begin
          ccx   <= vx[arc];
          ccy   <= vy[arc];
          ox    <= r_q;
          oy    <= '0;
          crit  <= ONE_K - KW'(r_q);
          oct   <= '0;
          state <= DRAW;
        end
        DONE: begin
          bus.done <= 1'b1;
          if (!bus.start && bus.done) begin
            bus.done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARC_SHAPE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.plot_count <= '0;
      bus.clip_count <= '0;
    end else if (state == IDLE && bus.start) begin
      bus.plot_count <= '0;
      bus.clip_count <= '0;
    end else if (state == DRAW && accept) begin
      if (on_scr) begin
        if (bus.plot_count != 16'hFFFF) bus.plot_count <= bus.plot_count + 16'd1;
      end else begin
        if (bus.clip_count != 16'hFFFF) bus.clip_count <= bus.clip_count + 16'd1;
      end
    end
  end
`endif
endmodule
